// File: rtl/img_preproc_pkg.sv
// rtl/img_preproc_pkg.sv - shared types and widths for the image preproc front end
package img_preproc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int IMG_DATA_W  = 32;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first request at or after start_i
module rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  int j;

  // Scan from the farthest candidate back to start_i so the nearest request wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = (int'(start_i) + k) % NUM_SRC;
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/img_frame_arbiter.sv
// rtl/img_frame_arbiter.sv - frame-granular round-robin arbiter feeding img_preproc
module img_frame_arbiter
  import img_preproc_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int DATA_W          = IMG_DATA_W,
  parameter int WORDS_PER_FRAME = 1024
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]    src_data,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_stall,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              out_valid,
  output logic [$clog2(NUM_SRC)-1:0]        out_src,
  output logic                              out_last,
  input  logic                              downstream_stall,
  output logic [FRAME_CNT_W-1:0]            frames_done
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_FRAME - 1);

  arb_state_t               state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         grant_id_q, grant_id_d;
  logic [CNT_W-1:0]         word_cnt_q, word_cnt_d;
  logic [FRAME_CNT_W-1:0]   frames_q, frames_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [IDX_W-1:0]         out_src_q, out_src_d;
  logic                     out_last_q, out_last_d;

  logic                     pick_found;
  logic [IDX_W-1:0]         pick_idx;
  logic                     load_en;
  logic                     xfer;
  logic                     is_last;

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (src_valid),
    .start_i (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign load_en = !out_valid_q || !downstream_stall;
  assign xfer    = (state_q == GRANT) && load_en && src_valid[grant_id_q];
  assign is_last = (word_cnt_q == LAST_CNT);

  always_comb begin
    src_stall = '1;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_stall[i] = !((state_q == GRANT) && (grant_id_q == IDX_W'(i)) && load_en);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    word_cnt_d  = word_cnt_q;
    frames_d    = frames_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          word_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (is_last) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_id_q + IDX_W'(1);
            frames_d = frames_q + FRAME_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output stage drains to empty whenever it may load but no word moves.
    if (load_en) begin
      if (xfer) begin
        out_data_d  = src_data[grant_id_q];
        out_valid_d = 1'b1;
        out_src_d   = grant_id_q;
        out_last_d  = is_last;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      word_cnt_q  <= '0;
      frames_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      word_cnt_q  <= word_cnt_d;
      frames_q    <= frames_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_src     = out_src_q;
  assign out_last    = out_last_q;
  assign frames_done = frames_q;

endmodule

// File: tb/tb_img_frame_arbiter.sv
// tb/tb_img_frame_arbiter.sv - directed bench for img_frame_arbiter (4 sources, 4-word frames)
module tb_img_frame_arbiter;

  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int WPF = 4;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NS-1:0][DW-1:0] src_data;
  logic [NS-1:0]         src_valid;
  logic [NS-1:0]         src_stall;
  logic [DW-1:0]         out_data;
  logic                  out_valid;
  logic [1:0]            out_src;
  logic                  out_last;
  logic                  downstream_stall;
  logic [15:0]           frames_done;

  img_frame_arbiter #(
    .NUM_SRC         (NS),
    .DATA_W          (DW),
    .WORDS_PER_FRAME (WPF)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .src_data         (src_data),
    .src_valid        (src_valid),
    .src_stall        (src_stall),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_src          (out_src),
    .out_last         (out_last),
    .downstream_stall (downstream_stall),
    .frames_done      (frames_done)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_chk  = 0;

  logic [31:0] mem [NS][16];
  int          rd [NS];
  int          wr [NS];
  logic [NS-1:0] en;

  logic [31:0] cap_data[$];
  logic [31:0] cap_src[$];
  logic [31:0] cap_last[$];
  logic [31:0] cap_cyc[$];
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      src_valid[i] = en[i] && (rd[i] < wr[i]);
      src_data[i]  = (rd[i] < wr[i]) ? mem[i][rd[i]] : '0;
    end
  endtask

  task automatic push(input int s, input logic [31:0] w);
    mem[s][wr[s]] = w;
    wr[s]++;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NS; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    en = '0;
  endtask

  // Handshakes are sampled mid-cycle; sources advance just after the edge.
  task automatic tick();
    logic [NS-1:0] x;
    @(negedge clock);
    x = src_valid & ~src_stall;
    if (out_valid && !downstream_stall) begin
      cap_data.push_back(out_data);
      cap_src.push_back(32'(out_src));
      cap_last.push_back(32'(out_last));
      cap_cyc.push_back(32'(cyc));
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < NS; i++) if (x[i]) rd[i]++;
    drive();
  endtask

  task automatic cap_clear();
    cap_data.delete();
    cap_src.delete();
    cap_last.delete();
    cap_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    downstream_stall = 1'b0;
    clear_srcs();
    drive();
    @(posedge clock);
    #1;
    reset = 1'b0;
    cap_clear();
    cyc = 0;
  endtask

  initial begin
    reset = 1'b1;
    downstream_stall = 1'b0;
    clear_srcs();
    drive();
    @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_frames", 32'(frames_done), 0);
    chk("rst_src_stall", 32'(src_stall), 32'hF);

    // Single source: words on cycles 2..5, last only on A3
    do_reset();
    for (int k = 0; k < 4; k++) push(0, 32'hA0 + k);
    en[0] = 1'b1;
    drive();
    tick();
    chk("s1_arb_valid", 32'(out_valid), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s1_data", out_data, 32'hA0 + k);
      chk("s1_valid", 32'(out_valid), 1);
      chk("s1_src", 32'(out_src), 0);
      chk("s1_last", 32'(out_last), 32'(k == 3));
      chk("s1_frames", 32'(frames_done), 32'(k == 3));
    end
    tick();
    chk("s1_drain_valid", 32'(out_valid), 0);

    // All sources contending: frames 0,1,2,3,0 with one bubble between frames
    do_reset();
    for (int k = 0; k < 8; k++) push(0, 32'h100 + k);
    for (int s = 1; s < NS; s++) for (int k = 0; k < 4; k++) push(s, 32'h100 * (s + 1) + k);
    en = '1;
    drive();
    repeat (30) tick();
    chk("s2_count", 32'(cap_data.size()), 20);
    for (int w = 0; w < 20 && w < cap_data.size(); w++) begin
      chk("s2_data", cap_data[w], 32'h100 * ((w / 4) % 4 + 1) + (w % 4) + ((w / 4 == 4) ? 4 : 0));
      chk("s2_src", cap_src[w], (w / 4) % 4);
      chk("s2_last", cap_last[w], 32'(w % 4 == 3));
      if (w > 0) chk("s2_spacing", cap_cyc[w] - cap_cyc[w-1], (w % 4 == 0) ? 2 : 1);
    end
    chk("s2_frames", 32'(frames_done), 5);

    // Downstream stall for 5 cycles while word 2 sits in the output register
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 32'hC0 + k);
    en[1] = 1'b1;
    drive();
    repeat (3) tick();
    chk("s3_pre_data", out_data, 32'hC1);
    downstream_stall = 1'b1;
    repeat (5) begin
      tick();
      chk("s3_hold_data", out_data, 32'hC1);
      chk("s3_hold_valid", 32'(out_valid), 1);
      chk("s3_hold_stall", 32'(src_stall[1]), 1);
    end
    downstream_stall = 1'b0;
    repeat (6) tick();
    chk("s3_count", 32'(cap_data.size()), 4);
    for (int w = 0; w < 4 && w < cap_data.size(); w++) chk("s3_data", cap_data[w], 32'hC0 + w);

    // Pointer wrap after src3 completes: src2 alone is granted
    do_reset();
    for (int k = 0; k < 4; k++) push(3, 32'h30 + k);
    en[3] = 1'b1;
    drive();
    repeat (6) tick();
    chk("s4_frames", 32'(frames_done), 1);
    for (int k = 0; k < 4; k++) push(2, 32'h20 + k);
    en[2] = 1'b1;
    drive();
    repeat (7) tick();
    chk("s4_count", 32'(cap_data.size()), 8);
    for (int w = 4; w < 8 && w < cap_data.size(); w++) begin
      chk("s4_src", cap_src[w], 2);
      chk("s4_data", cap_data[w], 32'h20 + w - 4);
    end

    // Source gap: src1 keeps the grant while src0 waits
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 32'hD0 + k);
    for (int k = 0; k < 4; k++) push(0, 32'hE0 + k);
    en[1] = 1'b1;
    drive();
    tick();
    en[0] = 1'b1;
    drive();
    repeat (2) tick();
    en[1] = 1'b0;
    drive();
    repeat (3) begin
      tick();
      chk("s5_gap_stall0", 32'(src_stall[0]), 1);
      chk("s5_gap_valid", 32'(out_valid), 0);
    end
    en[1] = 1'b1;
    drive();
    repeat (12) tick();
    chk("s5_count", 32'(cap_data.size()), 8);
    for (int w = 0; w < 8 && w < cap_data.size(); w++) begin
      chk("s5_src", cap_src[w], (w < 4) ? 1 : 0);
      chk("s5_data", cap_data[w], (w < 4) ? 32'hD0 + w : 32'hE0 + w - 4);
    end
    chk("s5_frames", 32'(frames_done), 2);

    // Asynchronous reset mid-frame after two words, then a clean src1 frame
    for (int k = 0; k < 4; k++) push(1, 32'hF0 + k);
    drive();
    repeat (3) tick();
    chk("s6_pre_data", out_data, 32'hF1);
    #3;
    reset = 1'b1;
    #1;
    chk("s6_async_valid", 32'(out_valid), 0);
    chk("s6_async_frames", 32'(frames_done), 0);
    chk("s6_async_stall", 32'(src_stall), 32'hF);
    @(posedge clock);
    #1;
    clear_srcs();
    for (int k = 0; k < 4; k++) push(1, 32'h60 + k);
    en[1] = 1'b1;
    drive();
    reset = 1'b0;
    cap_clear();
    repeat (8) tick();
    chk("s6_count", 32'(cap_data.size()), 4);
    for (int w = 0; w < 4 && w < cap_data.size(); w++) begin
      chk("s6_data", cap_data[w], 32'h60 + w);
      chk("s6_src", cap_src[w], 1);
      chk("s6_last", cap_last[w], 32'(w == 3));
    end
    chk("s6_frames", 32'(frames_done), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
